// File: rtl/gen_lane_packer_if.sv
// Handshake bundle for gen_lane_packer: a narrow beat stream in, a wide packed word out.
// The master side drives beats and accepts words; the slave side is the packer itself.
interface gen_lane_packer_if #(
   parameter int unsigned LANE_WIDTH = 4,
   parameter int unsigned LANES      = 4
) ();

   logic                        in_valid;
   logic                        in_ready;
   logic [LANE_WIDTH-1:0]       in_data;
   logic                        in_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES*LANE_WIDTH-1:0] out_data;
   logic [LANES-1:0]            out_keep;
   logic                        out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

endinterface

// File: rtl/gen_lane_packer.sv
// Gathers LANES narrow beats into one wide word. A beat with in_last closes the word
// early, leaving unwritten lanes at zero with their keep bits clear.
// The interface instance must carry the same LANE_WIDTH/LANES as this module.
module gen_lane_packer #(
   parameter int unsigned LANE_WIDTH = 4,
   parameter int unsigned LANES      = 4,
   parameter bit          LSB_FIRST  = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   gen_lane_packer_if.slave bus
);

   localparam int unsigned     IdxW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e                      state_q;
   logic [IdxW-1:0]             idx_q;
   logic                        out_valid_q;
   logic                        out_last_q;

   logic                        in_ready;
   logic                        accept;
   logic                        clear_all;
   logic                        close_word;
   logic [IdxW-1:0]             wr_idx;
   logic [IdxW-1:0]             tgt;
   logic [LANES*LANE_WIDTH-1:0] data;
   logic [LANES-1:0]            keep;

   // A held word frees the block only in the cycle the consumer takes it.
   assign in_ready  = (state_q == StFill) || bus.out_ready;
   assign accept    = bus.in_valid && in_ready;
   assign clear_all = (state_q == StHold) && bus.out_ready;

   // A beat accepted while a word is being drained always starts the next word.
   assign wr_idx     = (state_q == StFill) ? idx_q : '0;
   assign tgt        = LSB_FIRST ? wr_idx : (LastIdx - wr_idx);
   assign close_word = (wr_idx == LastIdx) || bus.in_last;

   // Fill/hold sequencing with registered out_valid and out_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFill;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            StFill: begin
               if (accept) begin
                  if (close_word) begin
                     state_q     <= StHold;
                     out_valid_q <= 1'b1;
                     out_last_q  <= bus.in_last;
                     idx_q       <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            StHold: begin
               if (bus.out_ready) begin
                  if (accept && close_word) begin
                     state_q     <= StHold;
                     out_valid_q <= 1'b1;
                     out_last_q  <= bus.in_last;
                     idx_q       <= '0;
                  end else if (accept) begin
                     state_q     <= StFill;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     idx_q       <= IdxW'(1);
                  end else begin
                     state_q     <= StFill;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     idx_q       <= '0;
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int unsigned Off = int'(i) * LANE_WIDTH;

      logic [LANE_WIDTH-1:0] lane_q;
      logic                  keep_q;
      logic                  wr;

      assign wr = accept && (tgt == IdxW'(i));

      // Lane storage: a write wins over the drain clear so a new word can start at once.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lane_q <= '0;
            keep_q <= 1'b0;
         end else if (wr) begin
            lane_q <= bus.in_data;
            keep_q <= 1'b1;
         end else if (clear_all) begin
            lane_q <= '0;
            keep_q <= 1'b0;
         end
      end

      assign data[Off +: LANE_WIDTH] = lane_q;
      assign keep[i]                 = keep_q;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data;
   assign bus.out_keep  = keep;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_gen_lane_packer.sv
// Self-checking bench for gen_lane_packer: LSB-first and MSB-first instances, with a
// scoreboard of expected words compared whenever the consumer takes a word.
module tb_gen_lane_packer;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic  clk;
   logic  rst_n;
   int    n_checks;
   int    n_pass;
   word_t q[$];
   word_t q_msb[$];
   word_t sb_exp;
   word_t msb_exp;

   gen_lane_packer_if #(.LANE_WIDTH(4), .LANES(4)) b ();
   gen_lane_packer_if #(.LANE_WIDTH(4), .LANES(4)) m ();

   gen_lane_packer #(.LANE_WIDTH(4), .LANES(4), .LSB_FIRST(1'b1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   gen_lane_packer #(.LANE_WIDTH(4), .LANES(4), .LSB_FIRST(1'b0)) u_dut_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard for the LSB-first instance.
   always @(negedge clk) begin
      if (rst_n && b.out_valid && b.out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got word %h, none expected", b.out_data);
         end else begin
            sb_exp = q.pop_front();
            n_checks++;
            if (b.out_data !== sb_exp.data)
               $display("FAIL sb_data: got %h exp %h", b.out_data, sb_exp.data);
            else n_pass++;
            n_checks++;
            if (b.out_keep !== sb_exp.keep)
               $display("FAIL sb_keep: got %b exp %b", b.out_keep, sb_exp.keep);
            else n_pass++;
            n_checks++;
            if (b.out_last !== sb_exp.last)
               $display("FAIL sb_last: got %b exp %b", b.out_last, sb_exp.last);
            else n_pass++;
         end
      end
   end

   // Scoreboard for the MSB-first instance.
   always @(negedge clk) begin
      if (rst_n && m.out_valid && m.out_ready) begin
         if (q_msb.size() == 0) begin
            n_checks++;
            $display("FAIL msb_unexpected: got word %h, none expected", m.out_data);
         end else begin
            msb_exp = q_msb.pop_front();
            n_checks++;
            if (m.out_data !== msb_exp.data)
               $display("FAIL msb_data: got %h exp %h", m.out_data, msb_exp.data);
            else n_pass++;
            n_checks++;
            if (m.out_keep !== msb_exp.keep)
               $display("FAIL msb_keep: got %b exp %b", m.out_keep, msb_exp.keep);
            else n_pass++;
            n_checks++;
            if (m.out_last !== msb_exp.last)
               $display("FAIL msb_last: got %b exp %b", m.out_last, msb_exp.last);
            else n_pass++;
         end
      end
   end

   task automatic idle();
      b.in_valid = 1'b0;
      b.in_last  = 1'b0;
   endtask

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input logic [3:0] d, input logic last, output int waits);
      waits      = 0;
      b.in_valid = 1'b1;
      b.in_data  = d;
      b.in_last  = last;
      @(negedge clk);
      while (!b.in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!b.in_ready) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready stuck at %b, need 1", b.in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int w;
      #12;
      n_checks++;
      if (b.out_valid !== 1'b0) $display("FAIL rst_hold_valid: got %b exp 0", b.out_valid);
      else n_pass++;
      n_checks++;
      if (b.out_keep !== 4'b0000) $display("FAIL rst_hold_keep: got %b exp 0000", b.out_keep);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (b.in_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", b.in_ready);
      else n_pass++;
      // Park a full word in HOLD, then reset asynchronously mid-cycle.
      b.out_ready = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= 4; k++) send_beat(4'(k), 1'b0, w);
      idle();
      n_checks++;
      if (b.out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b exp 1", b.out_valid);
      else n_pass++;
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (b.out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", b.out_valid);
      else n_pass++;
      n_checks++;
      if (b.out_data !== 16'h0000) $display("FAIL rst_data: got %h exp 0000", b.out_data);
      else n_pass++;
      n_checks++;
      if (b.out_keep !== 4'b0000) $display("FAIL rst_keep: got %b exp 0000", b.out_keep);
      else n_pass++;
      n_checks++;
      if (b.out_last !== 1'b0) $display("FAIL rst_last: got %b exp 0", b.out_last);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (b.in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", b.in_ready);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_full_word();
      int w;
      b.out_ready = 1'b1;
      q.push_back('{data: 16'h4321, keep: 4'b1111, last: 1'b0});
      for (int k = 1; k <= 4; k++) send_beat(4'(k), 1'b0, w);
      idle();
      n_checks++;
      if (b.out_valid !== 1'b1) $display("FAIL full_valid_rise: got %b exp 1", b.out_valid);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (b.out_valid !== 1'b0) $display("FAIL full_valid_fall: got %b exp 0", b.out_valid);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_partial();
      int w;
      b.out_ready = 1'b1;
      q.push_back('{data: 16'h00BA, keep: 4'b0011, last: 1'b1});
      send_beat(4'hA, 1'b0, w);
      send_beat(4'hB, 1'b1, w);
      idle();
      // Single-beat word: in_last on the first beat.
      q.push_back('{data: 16'h000C, keep: 4'b0001, last: 1'b1});
      send_beat(4'hC, 1'b1, w);
      idle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int w;
      b.out_ready = 1'b0;
      q.push_back('{data: 16'h4321, keep: 4'b1111, last: 1'b0});
      for (int k = 1; k <= 4; k++) send_beat(4'(k), 1'b0, w);
      b.in_valid = 1'b1;
      b.in_data  = 4'h5;
      b.in_last  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (b.in_ready !== 1'b0) $display("FAIL bp_ready c%0d: got %b exp 0", k, b.in_ready);
         else n_pass++;
         n_checks++;
         if (b.out_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b exp 1", k, b.out_valid);
         else n_pass++;
         n_checks++;
         if (b.out_data !== 16'h4321)
            $display("FAIL bp_data c%0d: got %h exp 4321", k, b.out_data);
         else n_pass++;
      end
      @(posedge clk); #1;
      b.out_ready = 1'b1;
      @(posedge clk); #1;
      idle();
      n_checks++;
      if (b.out_valid !== 1'b0) $display("FAIL bp_after_valid: got %b exp 0", b.out_valid);
      else n_pass++;
      n_checks++;
      if (b.out_keep !== 4'b0001) $display("FAIL bp_after_keep: got %b exp 0001", b.out_keep);
      else n_pass++;
      n_checks++;
      if (b.out_data !== 16'h0005) $display("FAIL bp_after_data: got %h exp 0005", b.out_data);
      else n_pass++;
      q.push_back('{data: 16'h8765, keep: 4'b1111, last: 1'b0});
      for (int k = 6; k <= 8; k++) send_beat(4'(k), 1'b0, w);
      idle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int w;
      int stalls;
      stalls      = 0;
      b.out_ready = 1'b1;
      q.push_back('{data: 16'h4321, keep: 4'b1111, last: 1'b0});
      q.push_back('{data: 16'h8765, keep: 4'b1111, last: 1'b0});
      for (int k = 1; k <= 8; k++) begin
         send_beat(4'(k), 1'b0, w);
         stalls += w;
      end
      idle();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (stalls !== 0) $display("FAIL stream_stalls: got %0d exp 0", stalls);
      else n_pass++;
   endtask

   task automatic test_msb_order();
      int stalls;
      stalls = 0;
      q_msb.push_back('{data: 16'h1234, keep: 4'b1111, last: 1'b0});
      for (int k = 1; k <= 4; k++) begin
         m.in_valid = 1'b1;
         m.in_data  = 4'(k);
         m.in_last  = 1'b0;
         @(negedge clk);
         if (!m.in_ready) stalls++;
         @(posedge clk); #1;
      end
      m.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (stalls !== 0) $display("FAIL msb_stalls: got %0d exp 0", stalls);
      else n_pass++;
   endtask

   task automatic test_reset_midfill();
      int w;
      b.out_ready = 1'b1;
      send_beat(4'h1, 1'b0, w);
      send_beat(4'h2, 1'b0, w);
      idle();
      #3;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (b.out_keep !== 4'b0000) $display("FAIL midfill_keep: got %b exp 0000", b.out_keep);
      else n_pass++;
      @(posedge clk); #1;
      q.push_back('{data: 16'h8765, keep: 4'b1111, last: 1'b0});
      for (int k = 5; k <= 8; k++) send_beat(4'(k), 1'b0, w);
      idle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      b.in_valid  = 1'b0;
      b.in_data   = '0;
      b.in_last   = 1'b0;
      b.out_ready = 1'b0;
      m.in_valid  = 1'b0;
      m.in_data   = '0;
      m.in_last   = 1'b0;
      m.out_ready = 1'b1;

      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_back_to_back();
      test_msb_order();
      test_reset_midfill();

      n_checks++;
      if (q.size() !== 0) $display("FAIL sb_leftover: got %0d words exp 0", q.size());
      else n_pass++;
      n_checks++;
      if (q_msb.size() !== 0) $display("FAIL msb_leftover: got %0d words exp 0", q_msb.size());
      else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, need completion");
      $fatal(1, "watchdog");
   end

endmodule
